// File: rtl/dmem_mmio_unit.sv
// dmem_mmio_unit: PMIPS data-side memory. Word-organised distributed RAM plus
// a memory-mapped peripheral page at 0xFF00 (LEDs, switches/buttons, interval
// timer with interrupt). Loads are combinational from the address; stores
// commit on the rising edge of clock.
// Optional feature macro: DMEM_BTN_EDGE_EN adds sticky, clear-on-read button
// rising-edge latches at 0xFF02 bits [11:8].
module dmem_mmio_unit #(
    parameter int unsigned RAM_WORDS = 128
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] dmemaddr,
    input  logic [15:0] dmemwdata,
    input  logic        dmemwrite,
    input  logic        dmemread,
    output logic [15:0] dmemrdata,
    input  logic [3:0]  sw,
    input  logic [3:0]  btn,
    output logic [7:0]  led,
    output logic        irq
);

    localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    // Peripheral word indices (byte address >> 1)
    localparam logic [14:0] WA_LED   = 15'h7F80;
    localparam logic [14:0] WA_IN    = 15'h7F81;
    localparam logic [14:0] WA_COUNT = 15'h7F82;
    localparam logic [14:0] WA_CMP   = 15'h7F83;
    localparam logic [14:0] WA_CTRL  = 15'h7F84;
    localparam logic [14:0] WA_PSC   = 15'h7F85;
    localparam logic [15:0] A_INPUT  = 16'hFF02;

    logic [15:0]   ram [RAM_WORDS];
    logic          in_ram;
    logic [AW-1:0] ram_idx;
    logic [14:0]   word;
    logic          ram_we;
    logic          wr_led, wr_count, wr_cmp, wr_ctrl, wr_psc;

    logic [15:0]   count_q, compare_q, prescale_q, psc_q;
    logic [2:0]    ctrl_q;
    logic          flag_q;
    logic [15:0]   count_d, psc_d;
    logic          flag_d;
    logic          tick, match;

    logic [3:0]    sw_m, sw_s, btn_m, btn_s;
    logic [3:0]    edge_bits;

    assign in_ram  = 32'(dmemaddr) < (2 * RAM_WORDS);
    assign ram_idx = dmemaddr[AW:1];
    assign word    = dmemaddr[15:1];
    assign ram_we  = dmemwrite && in_ram && !reset;

    assign wr_led   = dmemwrite && !in_ram && (word == WA_LED);
    assign wr_count = dmemwrite && !in_ram && (word == WA_COUNT);
    assign wr_cmp   = dmemwrite && !in_ram && (word == WA_CMP);
    assign wr_ctrl  = dmemwrite && !in_ram && (word == WA_CTRL);
    assign wr_psc   = dmemwrite && !in_ram && (word == WA_PSC);

    assign irq = flag_q & ctrl_q[2];

    // RAM write port; contents intentionally survive reset
    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram[ram_idx] <= dmemwdata;
        end
    end

    // Combinational load mux; shows pre-write state during a store
    always_comb begin
        dmemrdata = 16'h0000;
        if (in_ram) begin
            dmemrdata = ram[ram_idx];
        end else begin
            case (word)
                WA_LED:   dmemrdata = {8'h00, led};
                WA_IN:    dmemrdata = {4'h0, edge_bits, btn_s, sw_s};
                WA_COUNT: dmemrdata = count_q;
                WA_CMP:   dmemrdata = compare_q;
                WA_CTRL:  dmemrdata = {flag_q, 12'h000, ctrl_q};
                WA_PSC:   dmemrdata = prescale_q;
                default:  dmemrdata = 16'h0000;
            endcase
        end
    end

    // Timer next-state: software writes beat tick updates, match beats W1C
    always_comb begin
        tick    = ctrl_q[0] && (psc_q == 16'h0000);
        match   = tick && (count_q == compare_q);
        psc_d   = psc_q;
        count_d = count_q;
        flag_d  = flag_q;

        if (ctrl_q[0]) begin
            psc_d = tick ? prescale_q : (psc_q - 16'd1);
        end
        if (wr_psc) begin
            psc_d = dmemwdata;
        end

        if (tick) begin
            count_d = (match && ctrl_q[1]) ? 16'h0000 : (count_q + 16'd1);
        end
        if (wr_count) begin
            count_d = dmemwdata;
        end

        if (wr_ctrl && dmemwdata[15]) begin
            flag_d = 1'b0;
        end
        if (match) begin
            flag_d = 1'b1;
        end
    end

    // Peripheral and timer registers
    always_ff @(posedge clock) begin
        if (reset) begin
            led        <= 8'h00;
            count_q    <= 16'h0000;
            compare_q  <= 16'hFFFF;
            ctrl_q     <= 3'b000;
            flag_q     <= 1'b0;
            prescale_q <= 16'h0000;
            psc_q      <= 16'h0000;
        end else begin
            if (wr_led) begin
                led <= dmemwdata[7:0];
            end
            if (wr_cmp) begin
                compare_q <= dmemwdata;
            end
            if (wr_ctrl) begin
                ctrl_q <= dmemwdata[2:0];
            end
            if (wr_psc) begin
                prescale_q <= dmemwdata;
            end
            count_q <= count_d;
            psc_q   <= psc_d;
            flag_q  <= flag_d;
        end
    end

    // Two-flop synchronisers for the asynchronous board inputs
    always_ff @(posedge clock) begin
        if (reset) begin
            sw_m  <= 4'h0;
            sw_s  <= 4'h0;
            btn_m <= 4'h0;
            btn_s <= 4'h0;
        end else begin
            sw_m  <= sw;
            sw_s  <= sw_m;
            btn_m <= btn;
            btn_s <= btn_m;
        end
    end

`ifdef DMEM_BTN_EDGE_EN
    logic [3:0] edge_q;
    logic [3:0] rise;
    logic       clr_edge;

    // A rise is the next synchronised sample going high, so the edge bit
    // appears in the same cycle as the new btn_s value
    assign rise      = btn_m & ~btn_s;
    assign clr_edge  = dmemread && (dmemaddr == A_INPUT);
    assign edge_bits = edge_q;

    // Sticky edge latches, cleared by a load of the input register
    always_ff @(posedge clock) begin
        if (reset) begin
            edge_q <= 4'h0;
        end else begin
            edge_q <= (clr_edge ? 4'h0 : edge_q) | rise;
        end
    end
`else
    logic unused_read;

    assign unused_read = dmemread;
    assign edge_bits   = 4'h0;
`endif

endmodule

// File: tb/tb_dmem_mmio_unit.sv
// Scoreboard bench for dmem_mmio_unit: driver pushes expected outputs from a
// behavioural model, a negedge monitor pops and compares.
module tb_dmem_mmio_unit;

    localparam int unsigned RAM_WORDS = 128;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] dmemaddr, dmemwdata, dmemrdata;
    logic        dmemwrite, dmemread;
    logic [3:0]  sw, btn;
    logic [7:0]  led;
    logic        irq;

    dmem_mmio_unit #(.RAM_WORDS(RAM_WORDS)) dut (
        .clock(clock), .reset(reset), .dmemaddr(dmemaddr), .dmemwdata(dmemwdata),
        .dmemwrite(dmemwrite), .dmemread(dmemread), .dmemrdata(dmemrdata),
        .sw(sw), .btn(btn), .led(led), .irq(irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        chk_rd;
        logic [15:0] rd;
        logic [7:0]  led;
        logic        irq;
        int          tag;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc_n = 0;
    logic [3:0] sw_v = 4'h0;
    logic [3:0] btn_v = 4'h0;

    // Behavioural model state
    logic [15:0] mram [RAM_WORDS];
    logic        mvalid [RAM_WORDS];
    logic [7:0]  m_led;
    logic [15:0] m_count, m_compare, m_prescale, m_psc;
    logic [2:0]  m_ctrl;
    logic        m_flag;
    logic [3:0]  sw_age1, sw_age2, btn_age1, btn_age2, m_edge;

    function automatic void model_reset();
        m_led = 8'h00; m_count = 16'h0000; m_compare = 16'hFFFF; m_ctrl = 3'b000;
        m_flag = 1'b0; m_prescale = 16'h0000; m_psc = 16'h0000;
        sw_age1 = 4'h0; sw_age2 = 4'h0; btn_age1 = 4'h0; btn_age2 = 4'h0; m_edge = 4'h0;
    endfunction

    function automatic void model_read(input logic [15:0] a, output logic v, output logic [15:0] x);
        v = 1'b1;
        x = 16'h0000;
        if (32'(a) < 2 * RAM_WORDS) begin
            v = mvalid[int'(a >> 1)];
            x = mram[int'(a >> 1)];
        end else begin
            case ({a[15:1], 1'b0})
                16'hFF00: x = {8'h00, m_led};
                16'hFF02: x = {4'h0, m_edge, btn_age2, sw_age2};
                16'hFF04: x = m_count;
                16'hFF06: x = m_compare;
                16'hFF08: x = {m_flag, 12'h000, m_ctrl};
                16'hFF0A: x = m_prescale;
                default:  x = 16'h0000;
            endcase
        end
    endfunction

    function automatic logic model_tick();
        return m_ctrl[0] && (m_psc == 16'h0000);
    endfunction

    function automatic logic model_match();
        return model_tick() && (m_count == m_compare);
    endfunction

    function automatic void model_step(input logic r, input logic [15:0] a, input logic [15:0] d,
                                       input logic w, input logic rd, input logic [3:0] s,
                                       input logic [3:0] b);
        logic [15:0] wa, n_psc, n_count;
        logic        per, tk, mt, n_flag;
        logic [3:0]  n_edge;
        if (r) begin
            model_reset();
            return;
        end
        wa  = {a[15:1], 1'b0};
        per = w && !(32'(a) < 2 * RAM_WORDS);
        tk  = model_tick();
        mt  = model_match();
        n_psc = m_psc;
        if (m_ctrl[0]) n_psc = tk ? m_prescale : 16'(m_psc - 16'd1);
        if (per && wa == 16'hFF0A) n_psc = d;
        n_count = m_count;
        if (tk) n_count = (mt && m_ctrl[1]) ? 16'h0000 : 16'(m_count + 16'd1);
        if (per && wa == 16'hFF04) n_count = d;
        n_flag = m_flag;
        if (per && wa == 16'hFF08 && d[15]) n_flag = 1'b0;
        if (mt) n_flag = 1'b1;
        n_edge = m_edge;
`ifdef DMEM_BTN_EDGE_EN
        if (rd && a == 16'hFF02) n_edge = 4'h0;
        n_edge = n_edge | (btn_age1 & ~btn_age2);
`endif
        if (w && 32'(a) < 2 * RAM_WORDS) begin
            mram[int'(a >> 1)]   = d;
            mvalid[int'(a >> 1)] = 1'b1;
        end
        if (per && wa == 16'hFF00) m_led = d[7:0];
        if (per && wa == 16'hFF06) m_compare = d;
        if (per && wa == 16'hFF08) m_ctrl = d[2:0];
        if (per && wa == 16'hFF0A) m_prescale = d;
        m_psc = n_psc; m_count = n_count; m_flag = n_flag; m_edge = n_edge;
        sw_age2 = sw_age1; sw_age1 = s;
        btn_age2 = btn_age1; btn_age1 = b;
    endfunction

    // One bus cycle: drive, push expectation, advance model at the edge
    task automatic cyc(input logic r, input logic [15:0] a, input logic [15:0] d,
                       input logic w, input logic rd);
        exp_t        e;
        logic        v;
        logic [15:0] x;
        reset = r; dmemaddr = a; dmemwdata = d; dmemwrite = w; dmemread = rd;
        sw = sw_v; btn = btn_v;
        model_read(a, v, x);
        e.chk_rd = rd && v;
        e.rd     = x;
        e.led    = m_led;
        e.irq    = m_flag & m_ctrl[2];
        e.tag    = cyc_n;
        sbq.push_back(e);
        @(posedge clock);
        model_step(r, a, d, w, rd, sw_v, btn_v);
        #1;
        cyc_n++;
    endtask

    task automatic rd_(input logic [15:0] a);
        cyc(1'b0, a, 16'h0000, 1'b0, 1'b1);
    endtask

    task automatic wr_(input logic [15:0] a, input logic [15:0] d);
        cyc(1'b0, a, d, 1'b1, 1'b0);
    endtask

    // Monitor: compare presented outputs against the scoreboard
    always @(negedge clock) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.chk_rd) begin
                tests++;
                if (dmemrdata !== e.rd) begin
                    fails++;
                    $display("FAIL rdata cyc=%0d addr=%h got=%h exp=%h", e.tag, dmemaddr, dmemrdata, e.rd);
                end
            end
            tests++;
            if (led !== e.led) begin
                fails++;
                $display("FAIL led cyc=%0d got=%h exp=%h", e.tag, led, e.led);
            end
            tests++;
            if (irq !== e.irq) begin
                fails++;
                $display("FAIL irq cyc=%0d got=%b exp=%b", e.tag, irq, e.irq);
            end
        end
    end

    initial begin
        logic [15:0] a, d;
        logic        w, r, rs;
        int          k;
        for (int i = 0; i < RAM_WORDS; i++) begin
            mvalid[i] = 1'b0;
            mram[i]   = 16'h0000;
        end
        model_reset();
        reset = 1'b1; dmemaddr = 16'h0; dmemwdata = 16'h0; dmemwrite = 1'b0; dmemread = 1'b0;
        sw = 4'h0; btn = 4'h0;
        repeat (2) @(posedge clock);
        #1;

        // Reset values
        rd_(16'hFF00); rd_(16'hFF04); rd_(16'hFF06); rd_(16'hFF08); rd_(16'hFF0C);

        // RAM, out-of-range, LED, same-cycle write+read
        wr_(16'h0010, 16'h1234);
        rd_(16'h0010); rd_(16'h0011);
        wr_(16'h0100, 16'h5555);
        rd_(16'h0100);
        wr_(16'hFF00, 16'hAB12);
        rd_(16'hFF00);
        wr_(16'hFF00, 16'h0000);
        cyc(1'b0, 16'hFF00, 16'h00C3, 1'b1, 1'b1);
        rd_(16'hFF00);

        // Reset mid-operation: write discarded, RAM retained
        wr_(16'h0020, 16'h1111);
        cyc(1'b1, 16'h0020, 16'hBEEF, 1'b1, 1'b0);
        rd_(16'h0020); rd_(16'hFF00);

        // Timer: PRESCALE=3, COMPARE=4, auto-clear + irq enable
        wr_(16'hFF0A, 16'd3);
        wr_(16'hFF06, 16'd4);
        wr_(16'hFF08, 16'h0007);
        repeat (24) rd_(16'hFF04);
        wr_(16'hFF08, 16'h8007);
        rd_(16'hFF08);

        // W1C coinciding with a match tick
        k = 0;
        while (!model_match() && k < 200) begin rd_(16'hFF04); k++; end
        tests++;
        if (!model_match()) begin
            fails++;
            $display("FAIL match_wait got=none required=match within 200 cycles");
        end
        wr_(16'hFF08, 16'h8007);
        rd_(16'hFF08);

        // COUNT write coinciding with a tick
        k = 0;
        while (!model_tick() && k < 50) begin rd_(16'hFF08); k++; end
        wr_(16'hFF04, 16'h0100);
        rd_(16'hFF04);
        wr_(16'hFF08, 16'h8000);
        rd_(16'hFF08);

        // Button rising edge, clear-on-read
        btn_v = 4'h1;
        repeat (3) rd_(16'hFF00);
        rd_(16'hFF02); rd_(16'hFF02);
        btn_v = 4'h0;
        repeat (3) rd_(16'hFF02);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            k = int'($urandom_range(0, 9));
            if (k < 5)      a = 16'($urandom_range(0, 2 * RAM_WORDS + 63));
            else if (k < 9) a = 16'($urandom_range(16'hFF00, 16'hFF0F));
            else            a = 16'($urandom);
            d = 16'($urandom);
            if ({a[15:1], 1'b0} == 16'hFF0A) d = 16'($urandom_range(0, 3));
            if ({a[15:1], 1'b0} == 16'hFF06 || {a[15:1], 1'b0} == 16'hFF04) d = 16'($urandom_range(0, 9));
            if ({a[15:1], 1'b0} == 16'hFF08) d = {d[15], 12'h000, d[2:0] | 3'b001};
            w  = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 1) == 0);
            rs = ($urandom_range(0, 99) == 0);
            sw_v = 4'($urandom);
            if ($urandom_range(0, 5) == 0) btn_v = 4'($urandom);
            cyc(rs, a, d, w, r);
        end

        @(negedge clock);
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got=%0d left required=0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_mmio_unit.md
# dmem_mmio_unit

Data-side memory subsystem that sits directly downstream of the PMIPS pipeline's MEM stage. It consumes the core's `dmemaddr`/`dmemwdata`/`dmemwrite`/`dmemread` and returns `dmemrdata` in the same cycle. It holds a word-organised data RAM plus a memory-mapped peripheral page for board I/O: LEDs, switches/buttons and an interval timer with interrupt. It is the core's only data-memory target on the Spartan-3E board.

## Interface
- `RAM_WORDS`, 128: number of 16-bit RAM words; power of two, at most 32768.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `dmemaddr`  in  16  byte address from EX/MEM; bit 0 ignored (word access only).
- `dmemwdata`  in  16  store data.
- `dmemwrite`  in  1  store enable; committed at the rising edge.
- `dmemread`  in  1  load enable; qualifies read side effects only.
- `dmemrdata`  out  16  load data; combinational from address.
- `sw`  in  4  board switches; asynchronous.
- `btn`  in  4  board buttons; asynchronous.
- `led`  out  8  LED register.
- `irq`  out  1  timer interrupt = `flag & ctrl[2]`.

## Operation
- Address decode, with word index = `dmemaddr[15:1]`:
  - RAM: `dmemaddr < 2*RAM_WORDS`.
  - `0xFF00` LED: R/W. Holds the low 8 bits of the write; reads return `{8'h00, led}`.
  - `0xFF02` input: RO, `{4'h0, edge[3:0], btn_s, sw_s}`. `btn_s`/`sw_s` pass through a 2-flop synchroniser.
  - `0xFF04` COUNT: R/W, 16-bit timer count.
  - `0xFF06` COMPARE: R/W.
  - `0xFF08` CTRL/STATUS: bit0 enable, bit1 auto-clear-on-match, bit2 irq enable, bit15 match flag (sticky, write-1-to-clear). Other bits read 0.
  - `0xFF0A` PRESCALE: R/W. A write also loads the prescaler down-counter `psc`.
  - Any other address: reads 0, writes ignored.
- RAM is asynchronous-read distributed RAM, written on the edge. RAM contents are not cleared by `reset`.
- Timer, when `ctrl[0]=1` each cycle:
  - If `psc==0`: tick, and `psc<=PRESCALE`. Otherwise `psc<=psc-1`.
  - On a tick where `COUNT==COMPARE`: set flag, then `COUNT<=0` if `ctrl[1]`, else `COUNT<=COUNT+1`.
  - On a tick with no match: `COUNT<=COUNT+1`. Wraps `0xFFFF` to `0`.
- Timer when `ctrl[0]=0`: `psc` and `COUNT` hold.
- Simultaneous events:
  - A software write to COUNT beats a tick update in the same cycle.
  - Flag set by a match beats a write-1-to-clear in the same cycle.
  - A write to CTRL with bit15=0 leaves the flag unchanged.
  - `dmemwrite` and `dmemread` together: the write commits, and `dmemrdata` shows the pre-write value.

## Timing
- Reads: zero latency, combinational within the MEM cycle, so the core's MEM/WB register captures them at the same edge.
- Writes: visible to reads and on `led` from the cycle after the edge.
- Input latency: `sw`/`btn` reach the register 2 cycles after a change.
- Reset values:
  - `led=0`, `COUNT=0`, `COMPARE=0xFFFF`, `CTRL=0`, flag 0, `PRESCALE=0`, `psc=0`, synchroniser flops 0, edge latches 0, `irq=0`.
  - `dmemrdata` depends only on address and state, so it reflects these values immediately after reset.
- Reset mid-operation: all registers return to reset values at that edge. Any in-flight write is discarded; the RAM write is also suppressed while `reset=1`.

## Configuration
- `DMEM_BTN_EDGE_EN`
  - Defined: each `btn_s[i]` rising edge (0 to 1 on synchronised samples) sets sticky `edge[i]`.
  - A cycle with `dmemread=1` and `dmemaddr==0xFF02` clears all edge bits at that edge, i.e. clear-on-read. The read itself returns the pre-clear values.
  - A new edge in the clearing cycle wins: that bit stays 1.
  - Undefined: no edge logic; bits [11:8] read 0.

## Test plan
- Reset, then read `0xFF00`/`0xFF04`/`0xFF06`/`0xFF08`/`0xFF0C` -> `0x0000`/`0x0000`/`0xFFFF`/`0x0000`/`0x0000`; `led=0`, `irq=0`.
- Write `0x1234` to `0x0010`, read `0x0010` and `0x0011` -> both `0x1234`. Write to `0x0100` with `RAM_WORDS=128` is ignored; read `0x0100` -> `0`.
- Write `0xAB12` to `0xFF00` -> `led=0x12` the next cycle; read `0xFF00` -> `0x0012`. Same-cycle write+read of `0xFF00` returns old value `0x0000`.
- PRESCALE=3, COMPARE=4, CTRL=`0x0007`:
  - COUNT increments every 4 cycles.
  - Flag and `irq` assert 20 cycles after the enable write; COUNT returns to 0.
  - Writing `0x8007` to CTRL clears the flag and `irq` the next cycle.
- A CTRL write of `0x8007` coinciding with a match tick -> flag stays 1. A COUNT write of `0x0100` coinciding with a tick -> COUNT=`0x0100`.
- `btn[0]` 0 to 1:
  - With `DMEM_BTN_EDGE_EN`: first read of `0xFF02` shows bit8=1 and bit4=1; next read shows bit8=0.
  - Without `DMEM_BTN_EDGE_EN`: bit8 always 0.
